// File: rtl/switch_debouncer_if.sv
// Switch debouncer port bundle: raw switch levels in, clean levels and edge pulses out.
interface switch_debouncer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (output sw_in, input sw_out, input rise, input fall);
    modport slave  (input sw_in, output sw_out, output rise, output fall);
endinterface

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: 2-flop sync, then a per-channel counter/FSM filter that
// accepts a new level only after STABLE_CYCLES consecutive disagreeing samples.
module switch_debouncer_chan #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_e;

    logic          sync1_q, sync2_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d, fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any sample agreeing with the current level drops the count back to zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: if (sync2_q) begin
                state_d = WAIT_HI;
                cnt_d   = CNT_ONE;
            end
            WAIT_HI: begin
                if (!sync2_q) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: if (!sync2_q) begin
                state_d = WAIT_LO;
                cnt_d   = CNT_ONE;
            end
            WAIT_LO: begin
                if (sync2_q) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = STABLE_LO;
        endcase
    end

    always_comb begin
        sw_o   = (state_q == STABLE_HI) || (state_q == WAIT_LO);
        rise_o = rise_q;
        fall_o = fall_q;
    end
endmodule

module switch_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    switch_debouncer_if.slave  bus
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        switch_debouncer_chan #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .sw_i   (bus.sw_in[i]),
            .sw_o   (bus.sw_out[i]),
            .rise_o (bus.rise[i]),
            .fall_o (bus.fall[i])
        );
    end
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (WIDTH=2, STABLE_CYCLES=4) with a per-edge expectation queue.
module tb_switch_debouncer;
    localparam int W = 2;
    localparam int S = 4;

    typedef struct {
        string      tag;
        logic [1:0] out;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    switch_debouncer_if #(.WIDTH(W)) bus ();

    switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string field, input logic [1:0] obs, input logic [1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s %s observed=%b expected=%b", tag, field, obs, exp);
        end
    endtask

    // Drive one edge's inputs, queue the outputs expected after that edge, compare at the following negedge.
    task automatic step(input logic [1:0] sw, input logic r, input logic [1:0] eo,
                        input logic [1:0] er, input logic [1:0] ef, input string tag);
        exp_t e;
        bus.sw_in = sw;
        rst = r;
        e.tag = tag; e.out = eo; e.rise = er; e.fall = ef;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check(e.tag, "sw_out", bus.sw_out, e.out);
        check(e.tag, "rise", bus.rise, e.rise);
        check(e.tag, "fall", bus.fall, e.fall);
        check(e.tag, "rise&fall", bus.rise & bus.fall, 2'b00);
    endtask

    task automatic hold(input int n, input logic [1:0] sw, input logic r, input logic [1:0] eo, input string tag);
        for (int i = 0; i < n; i++) step(sw, r, eo, 2'b00, 2'b00, tag);
    endtask

    initial begin
        bus.sw_in = 2'b11;
        rst = 1'b1;

        // Reset with inputs high, then full S+2 latency after release
        hold(2, 2'b11, 1'b1, 2'b00, "reset");
        hold(5, 2'b11, 1'b0, 2'b00, "rel_wait");
        step(2'b11, 1'b0, 2'b11, 2'b11, 2'b00, "rel_rise");
        hold(1, 2'b11, 1'b0, 2'b11, "rel_after");

        // Both channels fall on the same edge
        hold(5, 2'b00, 1'b0, 2'b11, "both_wait");
        step(2'b00, 1'b0, 2'b00, 2'b00, 2'b11, "both_fall");
        hold(1, 2'b00, 1'b0, 2'b00, "both_after");

        // Channel 0 rise, channel 1 untouched
        hold(5, 2'b01, 1'b0, 2'b00, "ch0_wait");
        step(2'b01, 1'b0, 2'b01, 2'b01, 2'b00, "ch0_rise");
        hold(1, 2'b01, 1'b0, 2'b01, "ch0_after");
        hold(5, 2'b00, 1'b0, 2'b01, "ch0_lo_wait");
        step(2'b00, 1'b0, 2'b00, 2'b00, 2'b01, "ch0_fall");
        hold(1, 2'b00, 1'b0, 2'b00, "ch0_lo_after");

        // Bounce 1,0,1,1,0,1 then held 1: rise 5 edges after the final 0->1 edge
        step(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, "bounce");
        step(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, "bounce");
        step(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, "bounce");
        step(2'b01, 1'b0, 2'b00, 2'b00, 2'b00, "bounce");
        step(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, "bounce");
        hold(5, 2'b01, 1'b0, 2'b00, "bounce_hold");
        step(2'b01, 1'b0, 2'b01, 2'b01, 2'b00, "bounce_rise");
        hold(1, 2'b01, 1'b0, 2'b01, "bounce_after");

        // Channel 1: 3-cycle glitch rejected, 4-cycle pulse accepted
        hold(3, 2'b11, 1'b0, 2'b01, "glitch3");
        hold(6, 2'b01, 1'b0, 2'b01, "glitch3_after");
        hold(4, 2'b11, 1'b0, 2'b01, "pulse4_in");
        hold(1, 2'b01, 1'b0, 2'b01, "pulse4_wait");
        step(2'b01, 1'b0, 2'b11, 2'b10, 2'b00, "pulse4_rise");
        hold(3, 2'b01, 1'b0, 2'b11, "pulse4_hi");
        step(2'b01, 1'b0, 2'b01, 2'b00, 2'b10, "pulse4_fall");
        hold(1, 2'b01, 1'b0, 2'b01, "pulse4_after");

        // Reset mid-count discards progress; latency restarts from release
        hold(5, 2'b00, 1'b0, 2'b01, "pre_rst_wait");
        step(2'b00, 1'b0, 2'b00, 2'b00, 2'b01, "pre_rst_fall");
        hold(3, 2'b01, 1'b0, 2'b00, "midcnt");
        hold(2, 2'b01, 1'b1, 2'b00, "midcnt_rst");
        hold(5, 2'b01, 1'b0, 2'b00, "post_rst_wait");
        step(2'b01, 1'b0, 2'b01, 2'b01, 2'b00, "post_rst_rise");
        hold(1, 2'b01, 1'b0, 2'b01, "post_rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
